collective_eject_queue: RTL
===========================

Name: collective_eject_queue

Overview:
- Downstream ejection stage for the collective router's `top`.
- Captures every 82-bit Outpacket presented with valid_out and filters on local destination coordinates.
- Buffers accepted packets in a FIFO and presents decoded fields to the host over a valid/ready interface.
- Tracks the router's done pulse, and raises coll_complete once every packet of the collective has been delivered.

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- PKT_W, 82: packet width.
- CNT_W, 16: width of the accepted-packet count.

Ports:
- clk, input, 1: clock.
- rst, input, 1: one clock; reset is synchronous and active-low.
- pkt_in, input, 82: Outpacket from the router.
- pkt_valid, input, 1: valid_out from the router.
- coll_done, input, 1: done from the router; level, sampled each cycle.
- my_z, my_y, my_x, input, 3 each: local node coordinates.
- host_ready, input, 1: host accepts the head entry.
- host_valid, output, 1: head entry valid.
- host_src, output, 9: {src_z, src_y, src_x} of the head entry.
- host_rank, output, 9: rank of the head entry.
- host_ctx, output, 8: contextId of the head entry.
- host_tag, output, 8: tag of the head entry.
- host_op, output, 4: op of the head entry.
- host_payload, output, 32: payload of the head entry.
- coll_complete, output, 1: collective fully delivered.
- overflow, output, 1: sticky; packet dropped because the FIFO was full.
- misroute, output, 1: sticky; packet dropped because of a destination mismatch.
- pkt_count, output, CNT_W: packets accepted since reset or since leaving COMPLETE.

Behaviour:
- Packet layout, shared across the codebase:
  - [81] vld; [80:78] dst_z; [77:75] dst_y; [74:72] dst_x.
  - [71:69] src_z; [68:66] src_y; [65:63] src_x.
  - [62:54] rank; [53:46] contextId; [45:38] tag; [37:36] algtype; [35:32] op; [31:0] payload.
- Accept condition: pkt_valid && pkt_in[81] && dst equals {my_z, my_y, my_x} && FIFO not full.
- An accepted packet is written at the rising edge; it appears at host_valid in the next cycle (latency 1 when the FIFO was empty).
- No backpressure to the router:
  - Full FIFO → packet dropped, overflow set.
  - Destination mismatch → packet dropped, misroute set.
  - Mismatch takes precedence when both apply.
  - pkt_valid with vld=0 is ignored silently.
- Dequeue on host_valid && host_ready; the head advances the next cycle.
- Simultaneous enqueue and dequeue while full: both succeed, no overflow.
- Simultaneous enqueue and dequeue while empty: the entry is written; host_valid rises the next cycle (no bypass).
- host_* data fields are combinational from the FIFO head. They are don't-care when host_valid=0, but must hold stable while host_valid && !host_ready.
- Pointers are log2(DEPTH)+1 bits with wrap bit: full = MSBs differ and the rest are equal; empty = the pointers are equal.
- pkt_count increments by 1 per accepted packet and saturates at all-ones.
- FSM:
  - IDLE → STREAM on the first accepted packet.
  - STREAM → DRAIN when coll_done=1.
  - DRAIN → COMPLETE when the FIFO is empty and no enqueue occurs that cycle.
  - COMPLETE → IDLE when coll_done=0.
  - IDLE → COMPLETE directly if coll_done rises with no packet ever accepted.
- coll_complete = (state==COMPLETE), registered.
- Packets accepted in DRAIN are still enqueued and delay COMPLETE.
- Packets arriving in COMPLETE are enqueued. pkt_count clears on the COMPLETE→IDLE transition, or is set to 1 if a packet is accepted in that same cycle.
- Reset (rst=0 at an edge): pointers cleared, FIFO empty, state IDLE, and all outputs 0 (host_valid, coll_complete, overflow, misroute, pkt_count). Mid-operation reset discards the buffered contents.

Optional Feature:
- Macro EJECT_CTX_FILTER_EN.
- When defined:
  - Adds input ctx_filter[7:0] and input ctx_filter_en[0:0].
  - When ctx_filter_en=1, packets whose contextId differs from ctx_filter are dropped silently. They set no sticky flag and do not count.
- When undefined: those ports are absent and no context filtering occurs.

Decomposition:
- Package coll_pkg holds:
  - Packet field bit-position localparams, PKT_W=82, the coordinate width (3), and the field widths.
  - FSM state encoding: IDLE=2'd0, STREAM=2'd1, DRAIN=2'd2, COMPLETE=2'd3.
- One sub-module, eject_fifo: a parameterised synchronous FIFO with wr_en/rd_en, full/empty, and head data out.
- The filter, counters and FSM stay in the top module.

Test Plan:
- my=(0,0,0); 9 packets, dst 0, payloads 6,5,4,3,2,1,6,5,4, back-to-back, host_ready=1 → host_payload sequence identical; pkt_count=9; no flags set.
- host_ready=0, DEPTH=8, 10 back-to-back matching packets → first 8 buffered, overflow=1, pkt_count=8; after releasing host_ready the reads return the first 8 payloads in order.
- Packet with dst_x=1 while my_x=0 → not enqueued, misroute=1, host_valid stays 0.
- 3 packets buffered, coll_done=1, host_ready=0 → state DRAIN, coll_complete=0. host_ready=1 → coll_complete=1 one cycle after the last dequeue. coll_done=0 → IDLE, pkt_count=0.
- Full FIFO with simultaneous enqueue and dequeue → overflow stays 0; ordering preserved.
- rst=0 for 1 cycle with 4 entries queued → next cycle host_valid=0, pkt_count=0, flags 0, state IDLE.

Source files
------------

// File: rtl/coll_pkg.sv
// Shared definitions for the collective router: Outpacket field positions and
// the ejection FSM encoding.
package coll_pkg;

    localparam int PKT_W    = 82;
    localparam int COORD_W  = 3;

    localparam int VLD_BIT   = 81;
    localparam int DST_Z_LSB = 78;
    localparam int DST_Y_LSB = 75;
    localparam int DST_X_LSB = 72;
    localparam int SRC_LSB   = 63;
    localparam int SRC_W     = 3 * COORD_W;
    localparam int RANK_LSB  = 54;
    localparam int RANK_W    = 9;
    localparam int CTX_LSB   = 46;
    localparam int CTX_W     = 8;
    localparam int TAG_LSB   = 38;
    localparam int TAG_W     = 8;
    localparam int ALG_LSB   = 36;
    localparam int ALG_W     = 2;
    localparam int OP_LSB    = 32;
    localparam int OP_W      = 4;
    localparam int PAY_LSB   = 0;
    localparam int PAY_W     = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        DRAIN    = 2'd2,
        COMPLETE = 2'd3
    } state_t;

endpackage

// File: rtl/collective_eject_queue_fifo.sv
// eject_fifo: synchronous FIFO with wrap-bit pointers and a combinational head.
// The caller gates wr_en/rd_en; a write into a full FIFO is only legal with a read.
module eject_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 82
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr, rptr;
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + (AW+1)'(1);
            if (rd_en) rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage is not reset: empty pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
    end

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_data = mem[rptr[AW-1:0]];

endmodule

// File: rtl/collective_eject_queue.sv
// Ejection stage: destination filter, FIFO to the host, sticky drop flags,
// accepted-packet count and collective-completion FSM. Optional: EJECT_CTX_FILTER_EN.
module collective_eject_queue
    import coll_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PKT_W = coll_pkg::PKT_W,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PKT_W-1:0]   pkt_in,
    input  logic               pkt_valid,
    input  logic               coll_done,
    input  logic [2:0]         my_z,
    input  logic [2:0]         my_y,
    input  logic [2:0]         my_x,
`ifdef EJECT_CTX_FILTER_EN
    input  logic [7:0]         ctx_filter,
    input  logic [0:0]         ctx_filter_en,
`endif
    input  logic               host_ready,
    output logic               host_valid,
    output logic [8:0]         host_src,
    output logic [8:0]         host_rank,
    output logic [7:0]         host_ctx,
    output logic [7:0]         host_tag,
    output logic [3:0]         host_op,
    output logic [31:0]        host_payload,
    output logic               coll_complete,
    output logic               overflow,
    output logic               misroute,
    output logic [CNT_W-1:0]   pkt_count
);
    logic             pkt_ok, dst_match, ctx_ok, deq, accept, full, empty;
    logic             leave_complete;
    logic [PKT_W-1:0] head;
    state_t           state, state_nxt;

`ifdef EJECT_CTX_FILTER_EN
    assign ctx_ok = !ctx_filter_en[0] || (pkt_in[CTX_LSB +: CTX_W] == ctx_filter);
`else
    assign ctx_ok = 1'b1;
`endif

    // Context-filtered packets never reach the flag or count logic.
    assign pkt_ok    = pkt_valid && pkt_in[VLD_BIT] && ctx_ok;
    assign dst_match = (pkt_in[DST_Z_LSB +: COORD_W] == my_z) &&
                       (pkt_in[DST_Y_LSB +: COORD_W] == my_y) &&
                       (pkt_in[DST_X_LSB +: COORD_W] == my_x);
    assign host_valid = !empty;
    assign deq        = host_valid && host_ready;
    assign accept     = pkt_ok && dst_match && (!full || deq);

    eject_fifo #(.DEPTH(DEPTH), .W(PKT_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .rd_en   (deq),
        .wr_data (pkt_in),
        .full    (full),
        .empty   (empty),
        .rd_data (head)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
            misroute <= 1'b0;
        end else begin
            if (pkt_ok && !dst_match)                 misroute <= 1'b1;
            if (pkt_ok && dst_match && full && !deq)  overflow <= 1'b1;
        end
    end

    assign leave_complete = (state == COMPLETE) && !coll_done;

    always_ff @(posedge clk) begin
        if (!rst)
            pkt_count <= '0;
        else if (leave_complete)
            pkt_count <= accept ? CNT_W'(1) : '0;
        else if (accept && !(&pkt_count))
            pkt_count <= pkt_count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = STREAM;
                      else if (coll_done) state_nxt = COMPLETE;
            STREAM:   if (coll_done) state_nxt = DRAIN;
            DRAIN:    if (empty && !accept) state_nxt = COMPLETE;
            COMPLETE: if (!coll_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign coll_complete = (state == COMPLETE);

    assign host_src     = head[SRC_LSB  +: SRC_W];
    assign host_rank    = head[RANK_LSB +: RANK_W];
    assign host_ctx     = head[CTX_LSB  +: CTX_W];
    assign host_tag     = head[TAG_LSB  +: TAG_W];
    assign host_op      = head[OP_LSB   +: OP_W];
    assign host_payload = head[PAY_LSB  +: PAY_W];

    logic unused_head_bits;
    assign unused_head_bits = ^{head[VLD_BIT:DST_X_LSB], head[ALG_LSB +: ALG_W]};

endmodule
